dff_universal_reg: RTL and testbench

DFF_UNIVERSAL_REG -- requirements
Module: dff_universal_reg

---
 rtl/dff_universal_reg.sv | 101 ++++++++++
 tb/tb_dff_universal_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dff_universal_reg.sv
`default_nettype none
// ============================================================================
// dff_universal_reg : W-bit register with load, shift, rotate, inc/dec + carry
// Rev 1.0
// ============================================================================
module dff_universal_reg #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [W-1:0] d,
  input  logic         sin_l,
  input  logic         sin_r,
  output logic [W-1:0] q,
  output logic [W-1:0] q_n,
  output logic         carry
);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_LOAD = 3'b001;
  localparam logic [2:0] c_MODE_SHL  = 3'b010;
  localparam logic [2:0] c_MODE_SHR  = 3'b011;
  localparam logic [2:0] c_MODE_ROL  = 3'b100;
  localparam logic [2:0] c_MODE_ROR  = 3'b101;
  localparam logic [2:0] c_MODE_INC  = 3'b110;
  localparam logic [2:0] c_MODE_DEC  = 3'b111;

  localparam logic [W:0] c_ONE_EXT = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] c_ONE   = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] val_q, val_d;
  logic         carry_q, carry_d;
  logic [W:0]   inc_sum;

  // Increment is done one bit wider so the top bit becomes the carry out.
  assign inc_sum = {1'b0, val_q} + c_ONE_EXT;

  always_comb begin
    val_d   = val_q;
    carry_d = carry_q;
    if (en) begin
      case (mode)
        c_MODE_HOLD: begin
          val_d   = val_q;
          carry_d = carry_q;
        end
        c_MODE_LOAD: begin
          val_d   = d;
          carry_d = 1'b0;
        end
        c_MODE_SHL: begin
          val_d   = {val_q[W-2:0], sin_r};
          carry_d = val_q[W-1];
        end
        c_MODE_SHR: begin
          val_d   = {sin_l, val_q[W-1:1]};
          carry_d = val_q[0];
        end
        c_MODE_ROL: begin
          val_d   = {val_q[W-2:0], val_q[W-1]};
          carry_d = val_q[W-1];
        end
        c_MODE_ROR: begin
          val_d   = {val_q[0], val_q[W-1:1]};
          carry_d = val_q[0];
        end
        c_MODE_INC: begin
          val_d   = inc_sum[W-1:0];
          carry_d = inc_sum[W];
        end
        c_MODE_DEC: begin
          val_d   = val_q - c_ONE;
          carry_d = (val_q == '0);
        end
        default: begin
          val_d   = val_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q   <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      carry_q <= carry_d;
    end
  end

  assign q     = val_q;
  assign q_n   = ~val_q;
  assign carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_universal_reg.sv
`default_nettype none
// ============================================================================
// tb_dff_universal_reg : directed checks of dff_universal_reg at W=8, 2, 16
// Rev 1.0
// ============================================================================
module tb_dff_universal_reg;

  logic        clk = 1'b0;
  logic        reset, en, sin_l, sin_r;
  logic [2:0]  mode;
  logic [7:0]  d8,  q8,  qn8;
  logic [1:0]  d2,  q2,  qn2;
  logic [15:0] d16, q16, qn16;
  logic        carry8, carry2, carry16;
  logic [7:0]  inv8;
  logic [1:0]  inv2;
  logic [15:0] inv16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign inv8  = ~q8;
  assign inv2  = ~q2;
  assign inv16 = ~q16;

  dff_universal_reg #(.W(8), .RESET_VAL(8'hA5)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d8),
    .sin_l(sin_l), .sin_r(sin_r), .q(q8), .q_n(qn8), .carry(carry8)
  );

  dff_universal_reg #(.W(2), .RESET_VAL(2'b10)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d2),
    .sin_l(sin_l), .sin_r(sin_r), .q(q2), .q_n(qn2), .carry(carry2)
  );

  dff_universal_reg #(.W(16), .RESET_VAL(16'hA5A5)) u_dut16 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d16),
    .sin_l(sin_l), .sin_r(sin_r), .q(q16), .q_n(qn16), .carry(carry16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag,
                           input logic [7:0] e8,  input logic c8,
                           input logic [1:0] e2,  input logic c2,
                           input logic [15:0] e16, input logic c16);
    check({tag, " q8"},     64'(q8),      64'(e8));
    check({tag, " c8"},     64'(carry8),  64'(c8));
    check({tag, " qn8"},    64'(qn8),     64'(inv8));
    check({tag, " q2"},     64'(q2),      64'(e2));
    check({tag, " c2"},     64'(carry2),  64'(c2));
    check({tag, " qn2"},    64'(qn2),     64'(inv2));
    check({tag, " q16"},    64'(q16),     64'(e16));
    check({tag, " c16"},    64'(carry16), 64'(c16));
    check({tag, " qn16"},   64'(qn16),    64'(inv16));
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] v8, input logic [1:0] v2, input logic [15:0] v16);
    reset = r;
    en    = e;
    mode  = m;
    d8    = v8;
    d2    = v2;
    d16   = v16;
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'b000, 8'h00, 2'b00, 16'h0000);
    sin_l = 1'b0;
    sin_r = 1'b0;
    #1;

    // Reset, including reset overriding an active load
    tick();
    check_all("reset", 8'hA5, 1'b0, 2'b10, 1'b0, 16'hA5A5, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'hFF, 2'b11, 16'hFFFF);
    tick();
    check_all("reset_over_load", 8'hA5, 1'b0, 2'b10, 1'b0, 16'hA5A5, 1'b0);

    // Load, then hold with en=0 while mode selects increment
    drive(1'b0, 1'b1, 3'b001, 8'h3C, 2'b01, 16'h1234);
    tick();
    check_all("load", 8'h3C, 1'b0, 2'b01, 1'b0, 16'h1234, 1'b0);
    drive(1'b0, 1'b0, 3'b110, 8'hFF, 2'b11, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("en_off_hold", 8'h3C, 1'b0, 2'b01, 1'b0, 16'h1234, 1'b0);
    end

    // Shift
    drive(1'b0, 1'b1, 3'b001, 8'h81, 2'b11, 16'h8001);
    tick();
    check_all("load_shift", 8'h81, 1'b0, 2'b11, 1'b0, 16'h8001, 1'b0);
    drive(1'b0, 1'b1, 3'b010, 8'h00, 2'b00, 16'h0000);
    sin_l = 1'b1;
    sin_r = 1'b0;
    tick();
    check_all("shl", 8'h02, 1'b1, 2'b10, 1'b1, 16'h0002, 1'b1);
    mode  = 3'b011;
    sin_l = 1'b1;
    sin_r = 1'b1;
    tick();
    check_all("shr", 8'h81, 1'b0, 2'b11, 1'b0, 16'h8001, 1'b0);

    // Rotate
    mode = 3'b100;
    tick();
    check_all("rol", 8'h03, 1'b1, 2'b11, 1'b1, 16'h0003, 1'b1);
    mode = 3'b101;
    tick();
    check_all("ror", 8'h81, 1'b1, 2'b11, 1'b1, 16'h8001, 1'b1);
    mode = 3'b000;
    tick();
    check_all("mode_hold", 8'h81, 1'b1, 2'b11, 1'b1, 16'h8001, 1'b1);

    // Wrap
    drive(1'b0, 1'b1, 3'b001, 8'hFF, 2'b11, 16'hFFFF);
    tick();
    check_all("load_ones", 8'hFF, 1'b0, 2'b11, 1'b0, 16'hFFFF, 1'b0);
    mode = 3'b110;
    tick();
    check_all("inc_wrap", 8'h00, 1'b1, 2'b00, 1'b1, 16'h0000, 1'b1);
    tick();
    check_all("inc", 8'h01, 1'b0, 2'b01, 1'b0, 16'h0001, 1'b0);
    mode = 3'b111;
    tick();
    check_all("dec", 8'h00, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0);
    tick();
    check_all("dec_wrap", 8'hFF, 1'b1, 2'b11, 1'b1, 16'hFFFF, 1'b1);

    // Reset in the middle of an increment sequence
    drive(1'b0, 1'b1, 3'b001, 8'h10, 2'b10, 16'h0010);
    tick();
    check_all("load_10", 8'h10, 1'b0, 2'b10, 1'b0, 16'h0010, 1'b0);
    drive(1'b0, 1'b1, 3'b110, 8'h77, 2'b01, 16'h7777);
    tick();
    check_all("inc_1", 8'h11, 1'b0, 2'b11, 1'b0, 16'h0011, 1'b0);
    tick();
    check_all("inc_2", 8'h12, 1'b0, 2'b00, 1'b1, 16'h0012, 1'b0);
    reset = 1'b1;
    tick();
    check_all("reset_mid", 8'hA5, 1'b0, 2'b10, 1'b0, 16'hA5A5, 1'b0);
    reset = 1'b0;
    tick();
    check_all("inc_after_reset", 8'hA6, 1'b0, 2'b11, 1'b0, 16'hA5A6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
